fetch_sequencer: RTL and testbench

Instruction-fetch controller for the RV32I pipeline: owns the program counter, sequences requests to the instruction memory under a grant/response handshake, and presents one fetched instruction at a time to the decode stage. Accepts stall back-pressure from decode and PC redirects (taken branch, jal/jalr) from execute. It sits between the instruction memory port and the IF/ID boundary.

---
 rtl/fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Brief    : RV32I instruction-fetch controller. Owns the PC, runs the imem
//            grant/response handshake and holds one instruction for decode.
//            Optional macro MISALIGN_CHECK_EN: misaligned redirect targets
//            become fault slots instead of memory requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        if_fault_o
);

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_FULL = 3'd3,
        S_KILL = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_if_pc, w_if_pc_nxt;
    logic [31:0] r_if_instr, w_if_instr_nxt;
    logic        r_if_fault, w_if_fault_nxt;
    logic        r_fault_pend, w_fault_pend_nxt;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_drain;

`ifdef MISALIGN_CHECK_EN
    assign w_target     = redirect_pc_i;
    assign w_misaligned = |redirect_pc_i[1:0];
`else
    assign w_target     = redirect_pc_i & 32'hFFFF_FFFC;
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_if_pc      <= 32'h0000_0000;
            r_if_instr   <= C_NOP;
            r_if_fault   <= 1'b0;
            r_fault_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_if_pc      <= w_if_pc_nxt;
            r_if_instr   <= w_if_instr_nxt;
            r_if_fault   <= w_if_fault_nxt;
            r_fault_pend <= w_fault_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_if_pc_nxt      = r_if_pc;
        w_if_instr_nxt   = r_if_instr;
        w_if_fault_nxt   = r_if_fault;
        w_fault_pend_nxt = r_fault_pend;
        // A granted request still owed a response after this edge must drain
        w_drain = ((r_state == S_REQ) && imem_gnt_i) ||
                  (((r_state == S_WAIT) || (r_state == S_KILL)) && !imem_rvalid_i);

        if (redirect_valid_i) begin
            w_pc_nxt         = w_target;
            w_fault_pend_nxt = 1'b0;
            if (w_drain) begin
                w_state_nxt      = S_KILL;
                w_fault_pend_nxt = w_misaligned;
            end else if (w_misaligned) begin
                w_state_nxt    = S_FULL;
                w_if_pc_nxt    = w_target;
                w_if_instr_nxt = C_NOP;
                w_if_fault_nxt = 1'b1;
                w_pc_nxt       = w_target + 32'd4;
            end else begin
                w_state_nxt = S_REQ;
            end
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_REQ;
                S_REQ: begin
                    if (imem_gnt_i) w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        w_state_nxt    = S_FULL;
                        w_if_pc_nxt    = r_pc;
                        w_if_instr_nxt = imem_rdata_i;
                        w_if_fault_nxt = 1'b0;
                        w_pc_nxt       = r_pc + 32'd4;
                    end
                end
                S_FULL: begin
                    if (id_ready_i) w_state_nxt = S_REQ;
                end
                S_KILL: begin
                    if (imem_rvalid_i) begin
                        if (r_fault_pend) begin
                            // r_pc already holds the misaligned target
                            w_state_nxt      = S_FULL;
                            w_if_pc_nxt      = r_pc;
                            w_if_instr_nxt   = C_NOP;
                            w_if_fault_nxt   = 1'b1;
                            w_pc_nxt         = r_pc + 32'd4;
                            w_fault_pend_nxt = 1'b0;
                        end else begin
                            w_state_nxt = S_REQ;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign imem_req_o  = (r_state == S_REQ);
    assign imem_addr_o = r_pc;
    assign if_valid_o  = (r_state == S_FULL) && !redirect_valid_i;
    assign if_pc_o     = r_if_pc;
    assign if_instr_o  = r_if_instr;
    assign if_fault_o  = r_if_fault;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Self-checking bench for fetch_sequencer: directed vector table,
//            hand sequences and a randomized run against a fetch-order model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_sequencer;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        id_ready_i = 1'b0;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_fault_o;

    int checks = 0;
    int failures = 0;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .id_ready_i      (id_ready_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_instr_o      (if_instr_o),
        .if_fault_o      (if_fault_o)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the word address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [31:0] t, input logic rdy,
                         input logic g, input logic rv, input logic [31:0] d);
        redirect_valid_i = rd;
        redirect_pc_i    = t;
        id_ready_i       = rdy;
        imem_gnt_i       = g;
        imem_rvalid_i    = rv;
        imem_rdata_i     = d;
    endtask

    typedef struct {
        logic        rd;
        logic [31:0] tgt;
        logic        rdy;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rd, input logic [31:0] t, input logic rdy,
                       input logic g, input logic rv, input logic [31:0] d,
                       input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.rd = rd; v.tgt = t; v.rdy = rdy; v.gnt = g; v.rv = rv; v.rdata = d;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
        tbl.push_back(v);
    endtask

    // Randomized-run model state: architectural next-to-present PC
    logic [31:0] exp_pc;
    logic        pend_fault;
    logic        outst;
    logic [31:0] outst_addr;
    int          since_handoff;

    initial begin
        //   rd  tgt            rdy g  rv rdata                 req addr          vld pc            instr
        add(0, 0,             1, 0, 0, 0,                   0, 0,             0, 0,             0);             // IDLE
        add(0, 0,             1, 1, 0, 0,                   1, 0,             0, 0,             0);
        add(0, 0,             1, 0, 1, memf(0),             0, 0,             0, 0,             0);
        add(0, 0,             1, 0, 0, 0,                   0, 0,             1, 0,             memf(0));
        add(0, 0,             1, 1, 0, 0,                   1, 32'h4,         0, 0,             0);
        add(0, 0,             1, 0, 1, memf(4),             0, 0,             0, 0,             0);
        add(0, 0,             1, 0, 0, 0,                   0, 0,             1, 32'h4,         memf(4));
        add(0, 0,             1, 1, 0, 0,                   1, 32'h8,         0, 0,             0);
        add(0, 0,             1, 0, 1, memf(8),             0, 0,             0, 0,             0);
        for (int k = 0; k < 5; k++)
            add(0, 0,         0, 0, 0, 0,                   0, 0,             1, 32'h8,         memf(8));       // stall
        add(0, 0,             1, 0, 0, 0,                   0, 0,             1, 32'h8,         memf(8));
        add(0, 0,             1, 1, 0, 0,                   1, 32'hC,         0, 0,             0);
        add(1, 32'h100,       1, 0, 0, 0,                   0, 0,             0, 0,             0);             // redirect in WAIT
        add(0, 0,             1, 0, 0, 0,                   0, 0,             0, 0,             0);
        add(0, 0,             1, 0, 1, 32'hDEAD_BEEF,       0, 0,             0, 0,             0);
        add(0, 0,             1, 1, 0, 0,                   1, 32'h100,       0, 0,             0);
        add(0, 0,             1, 0, 1, memf(32'h100),       0, 0,             0, 0,             0);
        add(1, 32'hFFFF_FFFC, 1, 0, 0, 0,                   0, 0,             0, 0,             0);             // redirect in FULL
        add(0, 0,             1, 1, 0, 0,                   1, 32'hFFFF_FFFC, 0, 0,             0);
        add(0, 0,             1, 0, 1, memf(32'hFFFF_FFFC), 0, 0,             0, 0,             0);
        add(0, 0,             1, 0, 0, 0,                   0, 0,             1, 32'hFFFF_FFFC, memf(32'hFFFF_FFFC));
        add(0, 0,             1, 0, 0, 0,                   1, 32'h0,         0, 0,             0);             // wrapped, no grant
        add(0, 0,             1, 1, 0, 0,                   1, 32'h0,         0, 0,             0);
        add(0, 0,             1, 0, 1, memf(0),             0, 0,             0, 0,             0);
        add(0, 0,             1, 0, 0, 0,                   0, 0,             1, 32'h0,         memf(0));
        add(0, 0,             1, 0, 0, 0,                   1, 32'h4,         0, 0,             0);

        // Reset values
        drive(0, 0, 1, 0, 0, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk1("rst_req",   imem_req_o, 1'b0);
        chk ("rst_addr",  imem_addr_o, 32'h0);
        chk1("rst_valid", if_valid_o, 1'b0);
        chk ("rst_pc",    if_pc_o, 32'h0);
        chk ("rst_instr", if_instr_o, C_NOP);
        chk1("rst_fault", if_fault_o, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].rd, tbl[i].tgt, tbl[i].rdy, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
            #1;
            chk1($sformatf("row%0d_req", i), imem_req_o, tbl[i].e_req);
            if (tbl[i].e_req)
                chk($sformatf("row%0d_addr", i), imem_addr_o, tbl[i].e_addr);
            chk1($sformatf("row%0d_valid", i), if_valid_o, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d_pc", i), if_pc_o, tbl[i].e_pc);
                chk($sformatf("row%0d_instr", i), if_instr_o, tbl[i].e_instr);
                chk1($sformatf("row%0d_fault", i), if_fault_o, 1'b0);
            end
            @(negedge clk);
        end

        // Misaligned redirect while REQ at 4 without grant
        drive(1, 32'h102, 1, 0, 0, 0);
        #1;
        chk1("mis_redir_valid", if_valid_o, 1'b0);
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 0);
        #1;
`ifdef MISALIGN_CHECK_EN
        chk1("mis_req",   imem_req_o, 1'b0);
        chk1("mis_valid", if_valid_o, 1'b1);
        chk1("mis_fault", if_fault_o, 1'b1);
        chk ("mis_pc",    if_pc_o, 32'h102);
        chk ("mis_instr", if_instr_o, C_NOP);
        @(negedge clk);
        #1;
        chk1("mis_next_req",  imem_req_o, 1'b1);
        chk ("mis_next_addr", imem_addr_o, 32'h106);
`else
        chk1("mis_req",   imem_req_o, 1'b1);
        chk ("mis_addr",  imem_addr_o, 32'h100);
        chk1("mis_fault", if_fault_o, 1'b0);
`endif

        // Reset while WAIT; the late pre-reset response must be ignored
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 1, 0, 0);
        #1;
        chk("mrst_first_addr", imem_addr_o, 32'h0);
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk1("mrst_req",   imem_req_o, 1'b0);
        chk1("mrst_valid", if_valid_o, 1'b0);
        chk ("mrst_instr", if_instr_o, C_NOP);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 1, 0, 1, 32'hDEAD_BEEF);
        #1;
        chk1("mrst_idle_req", imem_req_o, 1'b0);
        @(negedge clk);
        drive(0, 0, 1, 1, 0, 0);
        #1;
        chk1("mrst_req_again", imem_req_o, 1'b1);
        chk ("mrst_addr",      imem_addr_o, 32'h0);
        @(negedge clk);
        drive(0, 0, 1, 0, 1, memf(0));
        #1;
        chk1("mrst_wait_valid", if_valid_o, 1'b0);
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 0);
        #1;
        chk1("mrst_valid2", if_valid_o, 1'b1);
        chk ("mrst_pc",     if_pc_o, 32'h0);
        chk ("mrst_instr2", if_instr_o, memf(0));

        // Randomized run against the fetch-order model
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_pc = 32'h0;
        pend_fault = 1'b0;
        outst = 1'b0;
        outst_addr = 32'h0;
        since_handoff = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic        rd, rdy, g, rv;
            logic [31:0] t;
            rd = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 9))
                0:       t = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                1:       t = $urandom;
                default: t = $urandom & 32'hFFFF_FFFC;
            endcase
            rdy = ($urandom_range(0, 3) != 0);
            g   = ($urandom_range(0, 1) == 1);
            rv  = outst && ($urandom_range(0, 1) == 1);
            drive(rd, t, rdy, g, rv, memf(outst_addr));
            #1;
            if (outst)
                chk1("rand_single_outstanding", imem_req_o, 1'b0);
            if (rd)
                chk1("rand_redirect_gate", if_valid_o, 1'b0);
            if (if_valid_o && rdy) begin
                chk("rand_handoff_pc", if_pc_o, exp_pc);
                if (pend_fault) begin
                    chk1("rand_fault_flag", if_fault_o, 1'b1);
                    chk ("rand_fault_instr", if_instr_o, C_NOP);
                end else begin
                    chk1("rand_fault_flag", if_fault_o, 1'b0);
                    chk ("rand_handoff_instr", if_instr_o, memf(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                pend_fault = 1'b0;
                since_handoff = 0;
            end else begin
                since_handoff++;
            end
            if (rv) outst = 1'b0;
            if (imem_req_o && g) begin
                if (!rd) begin
                    if (pend_fault)
                        chk1("rand_grant_during_fault", 1'b1, 1'b0);
                    else
                        chk("rand_grant_addr", imem_addr_o, exp_pc);
                end
                outst = 1'b1;
                outst_addr = imem_addr_o;
            end
            if (rd) begin
`ifdef MISALIGN_CHECK_EN
                exp_pc = t;
                pend_fault = (t[1:0] != 2'b00);
`else
                exp_pc = t & 32'hFFFF_FFFC;
                pend_fault = 1'b0;
`endif
            end
            if (since_handoff > 200) begin
                chk("rand_progress_cycles", 32'(since_handoff), 32'd200);
                break;
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
